// File: rtl/fp16_norm_round.sv
// Iterative normalize-and-round stage for the FP16 datapath.
// Each operation is accepted in IDLE. NORM then makes at most one shift per cycle.
// ROUND applies round-to-nearest-even and registers the final fields.
// DONE holds the result until the downstream stage accepts it.
module fp16_norm_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic        In_Sign,
    input  logic [5:0]  In_Exp,
    input  logic [16:0] In_Man,
    input  logic        In_Inf,
    input  logic        In_NaN,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic        Final_Sign,
    output logic [4:0]  Final_Exp,
    output logic [9:0]  Final_Man,
    output logic        Flag_Overflow,
    output logic        Flag_Inexact
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic [16:0] man_q, man_d;
    logic [5:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        nan_q, nan_d;
    logic        inf_q, inf_d;
    logic        lost_q, lost_d;

    logic        final_sign_q, final_sign_d;
    logic [4:0]  final_exp_q, final_exp_d;
    logic [9:0]  final_man_q, final_man_d;
    logic        ovf_q, ovf_d;
    logic        inexact_q, inexact_d;

    logic        rnd_guard;
    logic        rnd_sticky;
    logic        rnd_inc;
    logic [11:0] rnd_sum;
    logic [6:0]  rnd_exp;

    // Round-to-nearest-even on the working magnitude; exponent sized to catch saturation.
    always_comb begin
        rnd_guard  = man_q[4];
        rnd_sticky = |man_q[3:0];
        rnd_inc    = rnd_guard & (rnd_sticky | man_q[5]);
        rnd_sum    = {1'b0, man_q[15:5]} + {11'b0, rnd_inc};
        if (rnd_sum[11]) begin
            // Fraction overflowed into the next binade.
            rnd_exp = {1'b0, exp_q} + 7'd1;
        end else if (rnd_sum[10]) begin
            // A subnormal that rounds up into the hidden bit becomes exponent 1.
            rnd_exp = man_q[15] ? {1'b0, exp_q} : 7'd1;
        end else begin
            rnd_exp = 7'd0;
        end
    end

    // Next-state logic for the FSM, the working registers and the output registers.
    always_comb begin
        state_d      = state_q;
        man_d        = man_q;
        exp_d        = exp_q;
        sign_d       = sign_q;
        nan_d        = nan_q;
        inf_d        = inf_q;
        lost_d       = lost_q;
        final_sign_d = final_sign_q;
        final_exp_d  = final_exp_q;
        final_man_d  = final_man_q;
        ovf_d        = ovf_q;
        inexact_d    = inexact_q;

        unique case (state_q)
            StIdle: begin
                if (In_Valid) begin
                    man_d   = In_Man;
                    exp_d   = (In_Exp == 6'd0) ? 6'd1 : In_Exp;
                    sign_d  = In_Sign;
                    nan_d   = In_NaN;
                    inf_d   = In_Inf;
                    lost_d  = 1'b0;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (nan_q || inf_q || (man_q == 17'd0)) begin
                    state_d = StRound;
                end else if (man_q[16]) begin
                    // Keep the shifted-out bit alive in the sticky position.
                    man_d  = {1'b0, man_q[16:2], man_q[1] | man_q[0]};
                    exp_d  = exp_q + 6'd1;
                    lost_d = lost_q | man_q[0];
                end else if (!man_q[15] && (exp_q > 6'd1)) begin
                    man_d = {man_q[15:0], 1'b0};
                    exp_d = exp_q - 6'd1;
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                final_sign_d = sign_q;
                if (nan_q) begin
                    final_exp_d = 5'd31;
                    final_man_d = 10'h200;
                    ovf_d       = 1'b0;
                    inexact_d   = 1'b0;
                end else if (inf_q) begin
                    final_exp_d = 5'd31;
                    final_man_d = 10'h000;
                    ovf_d       = 1'b0;
                    inexact_d   = 1'b0;
                end else if (rnd_exp >= 7'd31) begin
                    final_exp_d = 5'd31;
                    final_man_d = 10'h000;
                    ovf_d       = 1'b1;
                    inexact_d   = rnd_guard | rnd_sticky | lost_q;
                end else begin
                    final_exp_d = rnd_exp[4:0];
                    final_man_d = rnd_sum[9:0];
                    ovf_d       = 1'b0;
                    inexact_d   = rnd_guard | rnd_sticky | lost_q;
                end
                state_d = StDone;
            end
            StDone: begin
                if (Out_Ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            man_q        <= 17'd0;
            exp_q        <= 6'd0;
            sign_q       <= 1'b0;
            nan_q        <= 1'b0;
            inf_q        <= 1'b0;
            lost_q       <= 1'b0;
            final_sign_q <= 1'b0;
            final_exp_q  <= 5'd0;
            final_man_q  <= 10'd0;
            ovf_q        <= 1'b0;
            inexact_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            man_q        <= man_d;
            exp_q        <= exp_d;
            sign_q       <= sign_d;
            nan_q        <= nan_d;
            inf_q        <= inf_d;
            lost_q       <= lost_d;
            final_sign_q <= final_sign_d;
            final_exp_q  <= final_exp_d;
            final_man_q  <= final_man_d;
            ovf_q        <= ovf_d;
            inexact_q    <= inexact_d;
        end
    end

    // Handshake flags decode straight from the state; final fields come from registers.
    always_comb begin
        In_Ready      = (state_q == StIdle);
        Out_Valid     = (state_q == StDone);
        Final_Sign    = final_sign_q;
        Final_Exp     = final_exp_q;
        Final_Man     = final_man_q;
        Flag_Overflow = ovf_q;
        Flag_Inexact  = inexact_q;
    end

endmodule

// File: tb/tb_fp16_norm_round.sv
// Self-checking bench for fp16_norm_round.
// The reference model rounds the exact input value arithmetically.
// It does not follow the shift sequence.
module tb_fp16_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [5:0]  in_exp;
    logic [16:0] in_man;
    logic        in_inf;
    logic        in_nan;
    logic        out_valid;
    logic        out_ready;
    logic        final_sign;
    logic [4:0]  final_exp;
    logic [9:0]  final_man;
    logic        flag_ovf;
    logic        flag_inx;

    int checks = 0;
    int errors = 0;

    fp16_norm_round u_dut (
        .clk           (clk),
        .rst           (rst),
        .In_Valid      (in_valid),
        .In_Ready      (in_ready),
        .In_Sign       (in_sign),
        .In_Exp        (in_exp),
        .In_Man        (in_man),
        .In_Inf        (in_inf),
        .In_NaN        (in_nan),
        .Out_Valid     (out_valid),
        .Out_Ready     (out_ready),
        .Final_Sign    (final_sign),
        .Final_Exp     (final_exp),
        .Final_Man     (final_man),
        .Flag_Overflow (flag_ovf),
        .Flag_Inexact  (flag_inx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // The value is In_Man * 2^(E-30). Pick the lowest kept bit L, then round the exact integer.
    function automatic void model(input logic s, input logic [5:0] ein, input logic [16:0] m,
                                  input logic inf, input logic nan,
                                  output logic [15:0] pk, output logic ovf,
                                  output logic inx, output int lat);
        int     e;
        int     p;
        int     l;
        int     lq;
        int     fe;
        longint x;
        longint kept;
        longint rem;
        longint half;
        e   = (ein == 6'd0) ? 1 : int'(ein);
        ovf = 1'b0;
        inx = 1'b0;
        lat = 2;
        if (nan) begin
            pk = {s, 5'd31, 10'h200};
            return;
        end
        if (inf) begin
            pk = {s, 5'd31, 10'h000};
            return;
        end
        if (m == 17'd0) begin
            pk = {s, 15'd0};
            return;
        end
        p = 0;
        for (int i = 0; i < 17; i++) if (m[i]) p = i;
        if (p == 16) lat = 3;
        else lat = 2 + (((15 - p) < (e - 1)) ? (15 - p) : (e - 1));
        l    = ((p - 10) > (6 - e)) ? (p - 10) : (6 - e);
        lq   = l + 16;
        x    = longint'(m) << 16;
        kept = x >> lq;
        rem  = x - (kept << lq);
        half = longint'(1) << (lq - 1);
        inx  = (rem != 0);
        if ((rem > half) || ((rem == half) && (kept % 2 == 1))) kept++;
        if (kept >= 2048) begin
            kept = kept >> 1;
            l++;
        end
        if (kept >= 1024) begin
            fe   = e + l - 5;
            kept = kept - 1024;
        end else begin
            fe = 0;
        end
        if (fe >= 31) begin
            fe   = 31;
            kept = 0;
            ovf  = 1'b1;
        end
        pk = {s, 5'(fe), 10'(kept)};
    endfunction

    // Runs one operation and checks its latency, result and flags, hold behaviour and handshake.
    task automatic run_op(input logic s, input logic [5:0] e, input logic [16:0] m,
                          input logic inf, input logic nan, input int stall);
        logic [15:0] exp_pk;
        logic        exp_ovf;
        logic        exp_inx;
        int          exp_lat;
        int          n;
        logic [17:0] snap;
        model(s, e, m, inf, nan, exp_pk, exp_ovf, exp_inx, exp_lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        in_inf   = inf;
        in_nan   = nan;
        @(posedge clk);
        #1;
        // Junk on the inputs while busy must be ignored.
        in_man   = 17'($urandom);
        in_exp   = 6'($urandom);
        in_nan   = 1'b0;
        in_inf   = 1'b0;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(exp_lat));
        check("result", 32'({final_sign, final_exp, final_man}), 32'(exp_pk));
        check("overflow", 32'(flag_ovf), 32'(exp_ovf));
        check("inexact", 32'(flag_inx), 32'(exp_inx));
        snap = {final_sign, final_exp, final_man, flag_ovf, flag_inx};
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_hold", 32'({final_sign, final_exp, final_man, flag_ovf, flag_inx}),
                  32'(snap));
            check("stall_valid", 32'({out_valid, in_ready}), 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_handshake", 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 6'd0;
        in_man    = 17'd0;
        in_inf    = 1'b0;
        in_nan    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'({in_ready, out_valid, final_sign, final_exp, final_man,
                                  flag_ovf, flag_inx}), 32'({1'b1, 19'd0}));
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(1'b0, 6'd15, 17'h08000, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd15, 17'h10000, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd15, 17'h10010, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd15, 17'h00800, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd3,  17'h01000, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd15, 17'h08030, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd15, 17'h08010, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd15, 17'h08018, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd30, 17'h0FFF0, 1'b0, 1'b0, 0);
        run_op(1'b1, 6'd15, 17'h08000, 1'b0, 1'b1, 0);
        run_op(1'b0, 6'd15, 17'h08000, 1'b1, 1'b0, 0);
        run_op(1'b1, 6'd0,  17'h00000, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd46, 17'h00001, 1'b0, 1'b0, 0);
        run_op(1'b0, 6'd1,  17'h07FF8, 1'b0, 1'b0, 0);
        run_op(1'b1, 6'd15, 17'h0C000, 1'b0, 1'b0, 5);

        // Abort an operation mid-normalization; the prior result must be cleared.
        @(negedge clk);
        in_valid = 1'b1;
        in_exp   = 6'd20;
        in_man   = 17'h00001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_state", 32'({in_ready, out_valid, final_sign, final_exp, final_man,
                                  flag_ovf, flag_inx}), 32'({1'b1, 19'd0}));
        run_op(1'b0, 6'd15, 17'h08030, 1'b0, 1'b0, 0);

        // Random operations with a spread of leading-one positions.
        for (int t = 0; t < 150; t++) begin
            logic [16:0] m;
            int          w;
            int          sel;
            w   = int'($urandom_range(0, 17));
            m   = 17'($urandom) & 17'((32'd1 << w) - 32'd1);
            sel = int'($urandom_range(0, 19));
            run_op(1'($urandom), 6'($urandom_range(0, 46)), m, sel == 0, sel == 1,
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
